// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor pattern history table:
// counter state names, default geometry and the saturation-limit helper.
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int DEF_INDEX_W = 4;
  localparam int DEF_CNT_W   = 2;

  // True when a counter of width cnt_w cannot move further in the taken/not-taken direction.
  function automatic logic cnt_at_limit(input int unsigned cnt, input int unsigned cnt_w,
                                        input logic taken);
    int unsigned max_v;
    max_v = (32'd1 << cnt_w) - 32'd1;
    if (taken) begin
      return (cnt == max_v);
    end else begin
      return (cnt == 32'd0);
    end
  endfunction

endpackage

// File: rtl/bp_sat_cnt_next.sv
// Combinational next-state for one CNT_W-bit saturating counter; also reports
// whether the requested move was blocked by a saturation limit.
module bp_sat_cnt_next
  import bp_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next,
  output logic             sat
);

  // Step the counter toward the resolved direction, holding at either end.
  always_comb begin
    sat      = cnt_at_limit(32'(cnt), 32'(CNT_W), taken);
    cnt_next = cnt;
    if (sat) begin
      cnt_next = cnt;
    end else if (taken) begin
      cnt_next = cnt + CNT_W'(1'b1);
    end else begin
      cnt_next = cnt - CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/bp_pht_table.sv
// Pattern history table: 2^INDEX_W saturating counters, combinational read,
// synchronous update. Define BP_PHT_BYPASS_EN for same-cycle read-after-update bypass.
module bp_pht_table
  import bp_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INIT_VAL = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic [INDEX_W-1:0] i_rd_idx,
  output logic [CNT_W-1:0]   o_rd_cnt,
  output logic               o_pred_taken,
  input  logic               i_upd_en,
  input  logic [INDEX_W-1:0] i_upd_idx,
  input  logic               i_upd_taken,
  output logic               o_upd_sat
);

  localparam int               DEPTH    = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);

  logic [CNT_W-1:0] table_r [DEPTH];
  logic             upd_sat_r;

  logic [CNT_W-1:0] upd_cur_s;
  logic [CNT_W-1:0] upd_next_s;
  logic             upd_sat_s;
  logic [CNT_W-1:0] stored_rd_s;
  logic [CNT_W-1:0] rd_cnt_s;

  assign upd_cur_s   = table_r[i_upd_idx];
  assign stored_rd_s = table_r[i_rd_idx];

  bp_sat_cnt_next #(
    .CNT_W (CNT_W)
  ) u_upd_next (
    .cnt      (upd_cur_s),
    .taken    (i_upd_taken),
    .cnt_next (upd_next_s),
    .sat      (upd_sat_s)
  );

  // Table and saturation flag; reset beats clear beats update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= INIT_CNT;
      end
      upd_sat_r <= 1'b0;
    end else begin
      if (i_upd_en) begin
        table_r[i_upd_idx] <= upd_next_s;
      end
      upd_sat_r <= i_upd_en & upd_sat_s;
    end
  end

`ifdef BP_PHT_BYPASS_EN
  logic [CNT_W-1:0] byp_next_s;
  logic             byp_sat_s;
  logic             byp_hit_s;

  bp_sat_cnt_next #(
    .CNT_W (CNT_W)
  ) u_byp_next (
    .cnt      (stored_rd_s),
    .taken    (i_upd_taken),
    .cnt_next (byp_next_s),
    .sat      (byp_sat_s)
  );

  assign byp_hit_s = i_upd_en & ~i_clr & i_rst_n & (i_upd_idx == i_rd_idx);

  // Forward the in-flight update when it targets the entry being read.
  always_comb begin
    rd_cnt_s = stored_rd_s;
    if (byp_hit_s && !byp_sat_s) begin
      rd_cnt_s = byp_next_s;
    end else begin
      rd_cnt_s = stored_rd_s;
    end
  end
`else
  // Read port shows stored state only; updates appear after the edge.
  always_comb begin
    rd_cnt_s = stored_rd_s;
  end
`endif

  assign o_rd_cnt     = rd_cnt_s;
  assign o_pred_taken = rd_cnt_s[CNT_W-1];
  assign o_upd_sat    = upd_sat_r;

endmodule

// File: tb/tb_bp_pht_table.sv
// Scoreboard bench for bp_pht_table: a default instance and a 6/3/3 instance.
module tb_bp_pht_table;

  typedef struct {
    string      name;
    int         dut;
    logic [2:0] cnt;
    logic       pred;
    logic       sat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] rd_idx = 4'd0;
  logic [3:0] upd_idx = 4'd0;
  logic       upd_en = 1'b0;
  logic       upd_taken = 1'b0;
  logic [1:0] rd_cnt;
  logic       pred;
  logic       upd_sat;

  logic [5:0] p_rd_idx = 6'd0;
  logic [5:0] p_upd_idx = 6'd0;
  logic       p_upd_en = 1'b0;
  logic       p_upd_taken = 1'b0;
  logic [2:0] p_rd_cnt;
  logic       p_pred;
  logic       p_upd_sat;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_pht_table dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_rd_idx(rd_idx),
    .o_rd_cnt(rd_cnt), .o_pred_taken(pred), .i_upd_en(upd_en),
    .i_upd_idx(upd_idx), .i_upd_taken(upd_taken), .o_upd_sat(upd_sat)
  );

  bp_pht_table #(.INDEX_W(6), .CNT_W(3), .INIT_VAL(3)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_rd_idx(p_rd_idx),
    .o_rd_cnt(p_rd_cnt), .o_pred_taken(p_pred), .i_upd_en(p_upd_en),
    .i_upd_idx(p_upd_idx), .i_upd_taken(p_upd_taken), .o_upd_sat(p_upd_sat)
  );

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] a_cnt;
    logic       a_pred;
    logic       a_sat;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.dut == 0) begin
        a_cnt = {1'b0, rd_cnt}; a_pred = pred; a_sat = upd_sat;
      end else begin
        a_cnt = p_rd_cnt; a_pred = p_pred; a_sat = p_upd_sat;
      end
      checks = checks + 1;
      if (a_cnt !== e.cnt) begin
        errors = errors + 1;
        $display("FAIL %s cnt: got %0d expected %0d", e.name, a_cnt, e.cnt);
      end
      checks = checks + 1;
      if (a_pred !== e.pred) begin
        errors = errors + 1;
        $display("FAIL %s pred: got %0b expected %0b", e.name, a_pred, e.pred);
      end
      checks = checks + 1;
      if (a_sat !== e.sat) begin
        errors = errors + 1;
        $display("FAIL %s sat: got %0b expected %0b", e.name, a_sat, e.sat);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int d, input logic [2:0] cnt, input logic sat);
    exp_t e;
    e.name = name; e.dut = d; e.cnt = cnt; e.sat = sat;
    e.pred = (d == 0) ? cnt[1] : cnt[2];
    exp_q.push_back(e);
  endtask

  // Read-only cycle on dut0 with expectation.
  task automatic rd0(input string name, input logic [3:0] idx, input logic [2:0] cnt, input logic sat);
    upd_en = 1'b0; rd_idx = idx;
    push(name, 0, cnt, sat);
    cyc();
  endtask

  // Unchecked update cycle on dut0, reading an unrelated index.
  task automatic upd0(input logic [3:0] idx, input logic taken);
    upd_en = 1'b1; upd_idx = idx; upd_taken = taken; rd_idx = 4'd15;
    cyc();
    upd_en = 1'b0;
  endtask

  task automatic rd1(input string name, input logic [5:0] idx, input logic [2:0] cnt, input logic sat);
    p_upd_en = 1'b0; p_rd_idx = idx;
    push(name, 1, cnt, sat);
    cyc();
  endtask

  task automatic upd1(input logic [5:0] idx, input logic taken);
    p_upd_en = 1'b1; p_upd_idx = idx; p_upd_taken = taken; p_rd_idx = 6'd0;
    cyc();
    p_upd_en = 1'b0;
  endtask

  localparam logic [2:0] UP_CNT [4]  = '{3'd2, 3'd3, 3'd3, 3'd3};
  localparam logic       UP_SAT [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic       DN_SAT [3]  = '{1'b0, 1'b1, 1'b1};
  localparam logic [2:0] P_CNT  [6]  = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
  localparam logic       P_SAT  [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [2:0] byp_exp;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) rd0("reset_sweep", 4'(i), 3'd1, 1'b0);
    rd1("p_reset_idx63", 6'd63, 3'd3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      upd1(6'd63, 1'b1);
      rd1("p_sat_up", 6'd63, P_CNT[i], P_SAT[i]);
    end

    for (int i = 0; i < 4; i++) begin
      upd0(4'd5, 1'b1);
      rd0("sat_up", 4'd5, UP_CNT[i], UP_SAT[i]);
    end

    clr = 1'b1; cyc(); clr = 1'b0;
    rd0("clear_idx5", 4'd5, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      upd0(4'd5, 1'b0);
      rd0("sat_down", 4'd5, 3'd0, DN_SAT[i]);
    end
    rd0("neighbor_idx4", 4'd4, 3'd1, 1'b0);
    rd0("neighbor_idx6", 4'd6, 3'd1, 1'b0);

    upd0(4'd3, 1'b1); upd0(4'd3, 1'b1); upd0(4'd3, 1'b1);
    rd0("idx3_full", 4'd3, 3'd3, 1'b1);
    clr = 1'b1; upd_en = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1;
    cyc();
    clr = 1'b0; upd_en = 1'b0;
    rd0("clr_beats_upd", 4'd3, 3'd1, 1'b0);

    rst_n = 1'b0; upd_en = 1'b1; upd_idx = 4'd8; upd_taken = 1'b1;
    cyc();
    rst_n = 1'b1; upd_en = 1'b0;
    rd0("rst_beats_upd", 4'd8, 3'd1, 1'b0);

`ifdef BP_PHT_BYPASS_EN
    byp_exp = 3'd2;
`else
    byp_exp = 3'd1;
`endif
    upd_en = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1; rd_idx = 4'd7;
    push("same_idx_cycle", 0, byp_exp, 1'b0);
    cyc();
    rd0("same_idx_next", 4'd7, 3'd2, 1'b0);

    upd_en = 1'b1; upd_idx = 4'd9; upd_taken = 1'b1; rd_idx = 4'd10;
    push("indep_rd", 0, 3'd1, 1'b0);
    cyc();
    rd0("indep_upd", 4'd9, 3'd2, 1'b0);

    cyc(); cyc();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_pht_table.md
Name: bp_pht_table

Overview:
- Parametrised pattern history table for the branch predictor: 2^INDEX_W entries, each a CNT_W-bit saturating counter.
- Generalises the fixed 4-way, 2-bit counter select into an N-entry, W-bit stateful table.
- Combinational read port feeds the fetch-stage prediction. The synchronous update port is driven from execute-stage branch resolution.

Parameters:
- INDEX_W, 4, index width; table depth = 2^INDEX_W entries.
- CNT_W, 2, counter width per entry (>=1).
- INIT_VAL, 1, reset/clear value of every entry (01 = weakly not-taken); must be < 2^CNT_W.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_clr  input  1  synchronous table clear (all entries to INIT_VAL).
- i_rd_idx  input  INDEX_W  fetch-stage read index.
- o_rd_cnt  output  CNT_W  counter value at i_rd_idx.
- o_pred_taken  output  1  prediction; equals MSB of o_rd_cnt.
- i_upd_en  input  1  update strobe from branch resolution.
- i_upd_idx  input  INDEX_W  entry to update.
- i_upd_taken  input  1  resolved direction (1 = taken).
- o_upd_sat  output  1  registered flag: the last accepted update hit a saturation limit.

Behaviour:
- Storage: 2^INDEX_W x CNT_W flops; no RAM macro.
- Reset: synchronous, active-low; evaluated only on i_clk rising edge. With i_rst_n=0 at an edge:
  - every entry <= INIT_VAL;
  - o_upd_sat <= 0.
  - After reset, o_rd_cnt = INIT_VAL for any index and o_pred_taken = INIT_VAL[CNT_W-1].
- Read: zero-cycle, purely combinational from stored state. o_rd_cnt = entry[i_rd_idx].
- Update: when i_upd_en=1 at an edge, entry[i_upd_idx] <= next value:
  - taken: cnt + 1, saturating at 2^CNT_W-1;
  - not-taken: cnt - 1, saturating at 0.
  - No wrap-around under any input.
  - The new value is visible on the read port the cycle after the edge (see optional feature for same-cycle bypass).
- o_upd_sat: registered each edge.
  - <= 1 if i_upd_en=1 and the counter was already at its limit in the direction of travel (max & taken, or 0 & not-taken).
  - <= 0 otherwise, including cycles with no update.
- Priority at the same edge: i_rst_n=0 > i_clr=1 > i_upd_en=1. With clr and update together the update is dropped and o_upd_sat <= 0.
- i_clr: same effect as reset on the entries and on o_upd_sat; single cycle.
- Only one update per cycle. Read and update of different indices are independent.
- Reset or clear asserted mid-sequence discards any in-flight update in that cycle. There is no pending state beyond the table itself.
- CNT_W=1 degenerates to a last-outcome bit: taken -> 1, not-taken -> 0.

Optional Feature:
- Macro: BP_PHT_BYPASS_EN.
- Defined: when i_upd_en=1, i_clr=0, i_rst_n=1 and i_upd_idx==i_rd_idx, o_rd_cnt (and o_pred_taken) show the post-update value in the same cycle. The stored entry still updates at the edge.
- Undefined: o_rd_cnt always shows the stored pre-update value; the update becomes visible one cycle later.

Decomposition:
- Package bp_pkg holds:
  - 2-bit state constants SNT=0, WNT=1, WT=2, ST=3;
  - default INDEX_W / CNT_W localparams;
  - the saturation-limit helper.
- Sub-module bp_sat_cnt_next (parametrised on CNT_W, combinational):
  - inputs: cnt, taken;
  - outputs: next cnt and sat flag.
  - Used once for the update path and reused for the bypass path.

Test Plan:
- Reset: hold i_rst_n=0 for 2 edges, release, sweep i_rd_idx 0..15 -> o_rd_cnt=01, o_pred_taken=0 for all; o_upd_sat=0.
- Saturate up: 4 taken updates to idx 5 -> reads 10, 11, 11, 11; o_pred_taken=1 from the 1st update on; o_upd_sat=0, 0, 1, 1 after edges 1-4.
- Saturate down: 3 not-taken updates to idx 5 from 01 -> reads 00, 00, 00; o_upd_sat=0, 1, 1; idx 4 and 6 remain 01.
- Clear vs update: set idx 3 to 11, then i_clr=1 with i_upd_en=1 (idx 3, taken) at the same edge -> idx 3 = 01, o_upd_sat=0.
- Same-index read/update: i_rd_idx=i_upd_idx=7 (stored 01), taken update:
  - with BP_PHT_BYPASS_EN, o_rd_cnt=10 in the same cycle;
  - without it, o_rd_cnt=01 that cycle and 10 the next.
- Parametric: INDEX_W=6, CNT_W=3, INIT_VAL=3 -> after reset idx 63 reads 011; 5 taken updates -> 111 with o_upd_sat=1 on the 5th; no wrap.
